// File: rtl/uart_cfg_pkg.sv
// Shared constants for the UART configuration front end.
package uart_cfg_pkg;

  // Power-on baud-rate word loaded into the store and the read register.
  localparam int DEFAULT_BAUD = 115200;

  // Width of the baud-rate configuration word.
  localparam int CFG_W = 32;

endpackage : uart_cfg_pkg

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser: a plain shift chain whose last stage is the output.
// STAGES must be 2..4; RST_LVL is the level every stage takes while RSTni is low.
module cdc_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_LVL = 1'b0
) (
  input  logic CLKip,
  input  logic RSTni,
  input  logic SIGi,
  output logic SIGo
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Next chain contents: shift the raw input into stage 0, pure wiring between stages.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], SIGi};
  end

  // Chain flops, preset to the idle level on reset so no false strobe leaves the chain.
  always_ff @(posedge CLKip or negedge RSTni) begin
    // NOTE: non-blocking assignment lets every stage sample the previous stage's old value.
    if (!RSTni) sync_q <= {STAGES{RST_LVL}};
    else        sync_q <= sync_d;
  end

  assign SIGo = sync_q[STAGES-1];

endmodule : cdc_sync_bit

// File: rtl/uart_cfg_sync_store.sv
// UART receiver front end: resynchronises RXi, WEi and RDi into the CLKip domain and
// holds one baud-rate word with a write-enabled store and a read-enabled output register.
module uart_cfg_sync_store
  import uart_cfg_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter int                DATA_W      = CFG_W,
  parameter logic [DATA_W-1:0] RST_VAL     = DATA_W'(DEFAULT_BAUD)
) (
  input  logic              CLKip,
  input  logic              RSTni,
  input  logic              RXi,
  input  logic              WEi,
  input  logic              RDi,
  input  logic [DATA_W-1:0] DATAi,
  output logic              RXo,
  output logic              WEo,
  output logic              RDo,
  output logic [DATA_W-1:0] Qo
);

  logic              we_s;
  logic              rd_s;
  logic [DATA_W-1:0] store_q;
  logic [DATA_W-1:0] store_d;
  logic [DATA_W-1:0] qo_q;
  logic [DATA_W-1:0] qo_d;

  // Serial line idles high, so its chain presets to 1 to avoid a phantom start bit.
  cdc_sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_LVL (1'b1)
  ) u_sync_rx (
    .CLKip (CLKip),
    .RSTni (RSTni),
    .SIGi  (RXi),
    .SIGo  (RXo)
  );

  cdc_sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_LVL (1'b0)
  ) u_sync_we (
    .CLKip (CLKip),
    .RSTni (RSTni),
    .SIGi  (WEi),
    .SIGo  (we_s)
  );

  cdc_sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_LVL (1'b0)
  ) u_sync_rd (
    .CLKip (CLKip),
    .RSTni (RSTni),
    .SIGi  (RDi),
    .SIGo  (rd_s)
  );

  assign WEo = we_s;
  assign RDo = rd_s;

  // Store next value: level-sensitive write, so every edge with WEo high captures DATAi.
  always_comb begin
    // NOTE: default to the held value first so the hold path is explicit and no latch forms.
    store_d = store_q;
    if (we_s) store_d = DATAi;
  end

  // Read register next value: takes the store as it was before this edge (read-before-write).
  always_comb begin
    qo_d = qo_q;
    if (rd_s) qo_d = store_q;
  end

  // Store and read register, both returning to the default baud word on reset.
  always_ff @(posedge CLKip or negedge RSTni) begin
    // NOTE: the store is a single register with a defined power-on word, so it is reset like any flop.
    if (!RSTni) begin
      store_q <= RST_VAL;
      qo_q    <= RST_VAL;
    end else begin
      store_q <= store_d;
      qo_q    <= qo_d;
    end
  end

  assign Qo = qo_q;

endmodule : uart_cfg_sync_store

// File: tb/tb_uart_cfg_sync_store.sv
// Self-checking bench for uart_cfg_sync_store: two instances (2 and 3 sync stages)
// compared every cycle against a history-based reference model, plus directed scenarios.
module tb_uart_cfg_sync_store;
  import uart_cfg_pkg::*;

  localparam int            W   = CFG_W;
  localparam logic [W-1:0]  RST = W'(DEFAULT_BAUD);

  logic         clk    = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst_n  = 1'b1;
  logic         rx     = 1'b1;
  logic         we     = 1'b0;
  logic         rd     = 1'b0;
  logic [W-1:0] data   = '0;

  logic         rxo2, weo2, rdo2;
  logic [W-1:0] qo2;
  logic         rxo3, weo3, rdo3;
  logic [W-1:0] qo3;

  int checks   = 0;
  int failures = 0;

  uart_cfg_sync_store #(.SYNC_STAGES(2)) dut2 (
    .CLKip (clk), .RSTni (rst_n), .RXi (rx), .WEi (we), .RDi (rd), .DATAi (data),
    .RXo (rxo2), .WEo (weo2), .RDo (rdo2), .Qo (qo2)
  );

  uart_cfg_sync_store #(.SYNC_STAGES(3)) dut3 (
    .CLKip (clk), .RSTni (rst_n), .RXi (rx), .WEi (we), .RDi (rd), .DATAi (data),
    .RXo (rxo3), .WEo (weo3), .RDo (rdo3), .Qo (qo3)
  );

  // Gated clock so reset can be checked with no clock running.
  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // ---------------- reference model ----------------
  // hist[0] is what was sampled at the latest edge, hist[n] n edges earlier.
  // With S stages an input sampled at edge k shows at the output after edge k+S-1,
  // and the store/read registers act on the strobe sampled S edges before the current one.
  typedef struct packed {
    logic         rx;
    logic         we;
    logic         rd;
    logic [W-1:0] data;
  } smp_t;

  smp_t         hist[$];
  logic [W-1:0] m_store [2:3];
  logic [W-1:0] m_qo    [2:3];
  logic [W-1:0] m_old;
  smp_t         m_smp;

  task automatic model_reset();
    smp_t idle;
    idle.rx   = 1'b1;
    idle.we   = 1'b0;
    idle.rd   = 1'b0;
    idle.data = '0;
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(idle);
    for (int s = 2; s <= 3; s++) begin
      m_store[s] = RST;
      m_qo[s]    = RST;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_smp.rx   = rx;
      m_smp.we   = we;
      m_smp.rd   = rd;
      m_smp.data = data;
      hist.push_front(m_smp);
      void'(hist.pop_back());
      for (int s = 2; s <= 3; s++) begin
        m_old = m_store[s];
        if (hist[s].we) m_store[s] = hist[0].data;
        if (hist[s].rd) m_qo[s]    = m_old;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("rxo2", W'(rxo2), W'(hist[1].rx));
    check("weo2", W'(weo2), W'(hist[1].we));
    check("rdo2", W'(rdo2), W'(hist[1].rd));
    check("qo2",  qo2,      m_qo[2]);
    check("rxo3", W'(rxo3), W'(hist[2].rx));
    check("weo3", W'(weo3), W'(hist[2].we));
    check("rdo3", W'(rdo3), W'(hist[2].rd));
    check("qo3",  qo3,      m_qo[3]);
  endtask

  // Advance one clock; inputs set after return are sampled on the next rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();

    // Reset with the clock stopped: outputs must take reset values immediately.
    #2 rst_n = 1'b0;
    #18;
    check("rst_rxo2", W'(rxo2), W'(1'b1));
    check("rst_weo2", W'(weo2), '0);
    check("rst_rdo2", W'(rdo2), '0);
    check("rst_qo2",  qo2,      RST);
    check("rst_rxo3", W'(rxo3), W'(1'b1));
    check("rst_qo3",  qo3,      RST);
    #5 rst_n  = 1'b1;
    clk_en    = 1'b1;

    // Read straight after reset returns the default word.
    pulse_rd();
    ticks(4);
    check("rd_after_rst", qo2, RST);

    // Write 9600, then read with exact latency on the 2-stage instance.
    data = W'(9600);
    we   = 1'b1;
    tick();
    we   = 1'b0;
    ticks(4);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("rd_lat_e1", qo2, RST);
    tick();
    check("rd_lat_e2", qo2, RST);
    tick();
    check("rd_lat_e3", qo2, W'(9600));
    ticks(2);
    check("rd_9600_s3", qo3, W'(9600));

    // Synchroniser latency: RXi falls between edges.
    rx = 1'b0;
    tick();
    check("rx_e1_s2", W'(rxo2), W'(1'b1));
    check("rx_e1_s3", W'(rxo3), W'(1'b1));
    tick();
    check("rx_e2_s2", W'(rxo2), W'(1'b0));
    check("rx_e2_s3", W'(rxo3), W'(1'b1));
    tick();
    check("rx_e3_s3", W'(rxo3), W'(1'b0));
    rx = 1'b1;
    ticks(4);

    // Simultaneous write and read: read returns the old word.
    data = W'(57600);
    we   = 1'b1;
    rd   = 1'b1;
    tick();
    we   = 1'b0;
    rd   = 1'b0;
    ticks(4);
    check("sim_old_s2", qo2, W'(9600));
    check("sim_old_s3", qo3, W'(9600));
    pulse_rd();
    ticks(4);
    check("sim_new_s2", qo2, W'(57600));
    check("sim_new_s3", qo3, W'(57600));

    // Reset one cycle into a write: the strobe in flight is discarded.
    data = W'(19200);
    we   = 1'b1;
    tick();
    rst_n = 1'b0;
    we    = 1'b0;
    #1;
    check("mid_rst_qo2",  qo2,      RST);
    check("mid_rst_weo2", W'(weo2), '0);
    check("mid_rst_qo3",  qo3,      RST);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);
    pulse_rd();
    ticks(4);
    check("mid_rst_rd2", qo2, RST);
    check("mid_rst_rd3", qo3, RST);

    // Hold: write 38400 for 100 cycles with no read; Qo must not move.
    data = W'(38400);
    we   = 1'b1;
    ticks(100);
    check("hold_qo2", qo2, RST);
    check("hold_qo3", qo3, RST);
    we = 1'b0;
    ticks(4);
    pulse_rd();
    ticks(4);
    check("hold_rd2", qo2, W'(38400));
    check("hold_rd3", qo3, W'(38400));

    // Randomised traffic: write bursts with stable data, random reads and line activity.
    for (int t = 0; t < 60; t++) begin
      data = W'($urandom);
      we   = 1'b1;
      for (int i = 0; i < int'($urandom_range(3, 1)); i++) begin
        rd = 1'($urandom_range(1, 0));
        rx = 1'($urandom_range(1, 0));
        tick();
      end
      we = 1'b0;
      for (int i = 0; i < 6; i++) begin
        rd = 1'($urandom_range(1, 0));
        rx = 1'($urandom_range(1, 0));
        tick();
      end
    end
    rd = 1'b0;
    rx = 1'b1;
    ticks(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_cfg_sync_store

// File: doc/uart_cfg_sync_store.md
Name: uart_cfg_sync_store

Overview:
Front-end utility block for the UART receiver path. It resynchronises the asynchronous serial line and the two baud-rate control strobes into the CLKip domain. It also holds a single baud-rate configuration word in a register store with write-enable and read-enable.
The UART FSM consumes the synchronised rx level and the registered baud-rate word Qo.

Parameters:
SYNC_STAGES, 2, number of flip-flops per synchroniser chain; legal range 2..4.
DATA_W, 32, width of the stored configuration word.
RST_VAL, 115200, value loaded into the store and into Qo on reset.

Ports:
CLKip  input  1  single system clock; all state on rising edge.
RSTni  input  1  reset, asynchronous assert, active-low; applies to every flop in the block.
RXi  input  1  asynchronous serial line.
WEi  input  1  asynchronous write-enable level/strobe for the store.
RDi  input  1  asynchronous read-enable level/strobe for the store.
DATAi  input  DATA_W  word to store; quasi-static, must be stable from WEi assertion until the write completes.
RXo  output  1  synchronised RXi.
WEo  output  1  synchronised WEi, for observation.
RDo  output  1  synchronised RDi, for observation.
Qo  output  DATA_W  registered read data.

Behaviour:
- Reset value of RXo is 1, the line-idle level. This is done by presetting its synchroniser chain to 1.
- Reset value of WEo and RDo is 0.
- Reset value of the store and of Qo is RST_VAL.
- Each synchroniser is a plain shift chain of SYNC_STAGES flops. No combinational logic sits between stages.
  - Output = last stage.
  - Input-to-output latency = SYNC_STAGES rising edges after the input is sampled.
- Store write: on a rising edge where WEo = 1, store <= DATAi.
  - WEi to store-updated latency = SYNC_STAGES + 1 edges.
- Read: on a rising edge where RDo = 1, Qo <= store.
  - While RDo = 0, Qo holds its value.
  - RDi to Qo-updated latency = SYNC_STAGES + 1 edges.
- Simultaneous WEo and RDo on the same edge is read-before-write:
  - Qo receives the old store value.
  - The store takes DATAi.
  - The new value is visible on the next RDo edge.
- WEo held high for N cycles writes DATAi on each of those cycles. This is level-sensitive; no edge detection.
- Reset asserted mid-operation clears everything asynchronously, with no clock needed. Any in-flight strobe in a chain is discarded.
- Reset release must be synchronous to CLKip. The system provides this; the block does not re-synchronise RSTni.
- No arithmetic inside the block. Qo is exactly the stored bit pattern with no truncation or extension.

Decomposition:
- Package uart_cfg_pkg holds:
  - constant DEFAULT_BAUD = 115200;
  - constant CFG_W = 32.
- Submodule cdc_sync_bit is instantiated three times:
  - parameters STAGES and RST_LVL;
  - ports CLKip, RSTni, SIGi, SIGo.
- The store and read register are inline in the top.

Test Plan:
- Reset: assert RSTni = 0 with no clock -> RXo = 1, WEo = 0, RDo = 0, Qo = 115200 immediately. Release, then pulse RDi for 1 cycle -> Qo = 115200 after 3 edges.
- Write then read: DATAi = 9600, WEi high for 1 cycle, then RDi high for 1 cycle -> Qo = 9600 exactly 3 edges after RDi is sampled. Qo is unchanged before that edge.
- Synchroniser latency: toggle RXi 1->0 between edges -> RXo falls on exactly the 2nd following edge. Repeat with SYNC_STAGES = 3 -> 3rd edge.
- Simultaneous strobes: store = 9600, DATAi = 57600, WEi and RDi high together for 1 cycle -> Qo = 9600. A second RDi pulse -> Qo = 57600.
- Reset mid-write: WEi asserted with DATAi = 19200, RSTni low 1 cycle after -> store remains 115200 and subsequent read gives 115200.
- Hold behaviour: RDi = 0 for 100 cycles while writing 38400 -> Qo does not change until the next RDi pulse, which then gives 38400.
